// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types and widths for the MAC sequencer
package mac_pkg;

  localparam int OP_W   = 16;
  localparam int PROD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ACCUM,
    ST_OUTPUT
  } state_e;

  typedef struct packed {
    logic            last;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } fifo_entry_t;

endpackage

// File: rtl/operand_fifo.sv
// rtl/operand_fifo.sv - synchronous operand FIFO with full/empty flags
module operand_fifo
  import mac_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        push,
  input  fifo_entry_t push_data,
  input  logic        pop,
  output fifo_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  fifo_entry_t mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // Extra pointer bit tells full from empty when the addresses match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty)
        rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge Clock) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - buffers operand pairs, drives an external multiplier, accumulates per vector
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ACC_W = 40
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic              in_last,
  output logic              mul_start,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic [PROD_W-1:0] mul_product,
  input  logic              mul_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [15:0]       out_count,
  output logic              out_overflow
);

  state_e      state_q, state_d;
  fifo_entry_t push_data;
  fifo_entry_t head;
  logic        fifo_full, fifo_empty, fifo_push, fifo_pop;

  logic [OP_W-1:0]   op_a_q, op_b_q;
  logic              op_last_q;
  logic [PROD_W-1:0] prod_q;
  logic [ACC_W-1:0]  acc_q;
  logic [15:0]       count_q;
  logic              ovf_q;
  logic [ACC_W:0]    acc_sum;

  assign push_data = '{last: in_last, a: in_a, b: in_b};
  assign fifo_push = in_valid && !fifo_full;
  assign fifo_pop  = (state_q == ST_ISSUE);
  assign in_ready  = !fifo_full;

  operand_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clock     (Clock),
    .Reset     (Reset),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE:   if (!fifo_empty) state_d = ST_ISSUE;
      ST_ISSUE: begin
        mul_start = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT:   if (mul_done) state_d = ST_ACCUM;
      ST_ACCUM:  state_d = op_last_q ? ST_OUTPUT : ST_IDLE;
      ST_OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Operands are latched from the head on the way into ISSUE so K sees them on its Start edge.
  assign mul_a = op_a_q;
  assign mul_b = op_b_q;

  assign acc_sum = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_q};

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_last_q <= 1'b0;
      prod_q    <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            op_a_q    <= head.a;
            op_b_q    <= head.b;
            op_last_q <= head.last;
          end
        end
        ST_WAIT: begin
          if (mul_done)
            prod_q <= mul_product;
        end
        ST_ACCUM: begin
          acc_q <= acc_sum[ACC_W-1:0];
          if (acc_sum[ACC_W])
            ovf_q <= 1'b1;
          if (count_q != 16'hFFFF)
            count_q <= count_q + 16'd1;
        end
        ST_OUTPUT: begin
          if (out_ready) begin
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sum      = acc_q;
  assign out_count    = count_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// tb/tb_mac_sequencer.sv - scoreboard bench for mac_sequencer with a behavioural multiplier
module tb_mac_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_last = 1'b0;
  logic        mul_start;
  logic [15:0] mul_a, mul_b;
  logic [31:0] mul_product;
  logic        mul_done;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [39:0] out_sum;
  logic [15:0] out_count;
  logic        out_overflow;

  int errors = 0;
  int checks = 0;
  int starts = 0;

  typedef struct packed {
    logic [39:0] sum;
    logic [15:0] cnt;
    logic        ovf;
  } exp_t;
  exp_t sb_q[$];

  always #5 Clock = ~Clock;

  mac_sequencer #(.DEPTH(4), .ACC_W(40)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_last      (in_last),
    .mul_start    (mul_start),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_product  (mul_product),
    .mul_done     (mul_done),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_count    (out_count),
    .out_overflow (out_overflow)
  );

  // Behavioural K: latches operands on Start, Done after 2 cycles for zero, 3..6 otherwise.
  logic [15:0] k_a, k_b;
  logic [3:0]  k_cnt;
  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      k_cnt       <= '0;
      mul_done    <= 1'b0;
      mul_product <= '0;
      k_a         <= '0;
      k_b         <= '0;
    end else if (mul_start) begin
      k_a      <= mul_a;
      k_b      <= mul_b;
      mul_done <= 1'b0;
      k_cnt    <= (mul_a == 16'd0 || mul_b == 16'd0) ? 4'd2 : 4'd3 + {2'b00, mul_a[1:0]};
    end else if (k_cnt != 4'd0) begin
      k_cnt <= k_cnt - 4'd1;
      if (k_cnt == 4'd1) begin
        mul_done    <= 1'b1;
        mul_product <= 32'(k_a) * 32'(k_b);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops, Start pulse width, operand stability while K works.
  logic        prev_start = 1'b0;
  logic        in_op = 1'b0;
  logic [31:0] op_cap = '0;
  always @(negedge Clock) begin
    if (Reset) begin
      in_op      = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (mul_start) begin
        starts++;
        check("start_width", 64'(prev_start), 64'd0);
      end
      if (out_valid)
        check("no_start_in_output", 64'(mul_start), 64'd0);
      if (in_op) begin
        check("operand_stable", 64'({mul_a, mul_b}), 64'(op_cap));
        if (mul_done) in_op = 1'b0;
      end
      if (mul_start) begin
        in_op  = 1'b1;
        op_cap = {mul_a, mul_b};
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got sum 0x%0h with no expected result pending", out_sum);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("out_sum", 64'(out_sum), 64'(e.sum));
          check("out_count", 64'(out_count), 64'(e.cnt));
          check("out_overflow", 64'(out_overflow), 64'(e.ovf));
        end
      end
      prev_start = mul_start;
    end
  end

  task automatic push_pair(input logic [15:0] a, input logic [15:0] b, input logic last);
    int guard = 0;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    while (!in_ready && guard < 2000) begin
      @(negedge Clock);
      guard++;
    end
    if (guard >= 2000) check("push_timeout", 64'd1, 64'd0);
    @(posedge Clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push_run(input logic [15:0] a, input logic [15:0] b, input int n);
    for (int i = 1; i <= n; i++)
      push_pair(a, b, i == n);
  endtask

  task automatic expect_result(input logic [39:0] s, input logic [15:0] c, input logic o);
    exp_t e;
    e.sum = s; e.cnt = c; e.ovf = o;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((sb_q.size() != 0 || out_valid) && guard < 5000) begin
      @(negedge Clock);
      guard++;
    end
    check("drain", 64'(sb_q.size()), 64'd0);
    repeat (3) @(negedge Clock);
  endtask

  initial begin
    repeat (3) @(negedge Clock);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_mul_start", 64'(mul_start), 64'd0);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    Reset = 1'b0;
    @(negedge Clock);

    expect_result(40'd42, 16'd3, 1'b0);
    push_pair(16'd3, 16'd4, 1'b0);
    push_pair(16'd5, 16'd6, 1'b0);
    push_pair(16'd0, 16'd9, 1'b1);
    wait_drain();

    expect_result(40'hFFFE000100, 16'd256, 1'b0);
    push_run(16'hFFFF, 16'hFFFF, 256);
    wait_drain();

    expect_result(40'h00FDFE0101, 16'd257, 1'b1);
    push_run(16'hFFFF, 16'hFFFF, 257);
    wait_drain();

    // Hold the result; the FIFO keeps filling but nothing is issued.
    out_ready = 1'b0;
    expect_result(40'd6, 16'd1, 1'b0);
    push_pair(16'd2, 16'd3, 1'b1);
    begin
      int guard = 0;
      while (!out_valid && guard < 200) begin
        @(negedge Clock);
        guard++;
      end
      check("hold_out_valid_seen", 64'(out_valid), 64'd1);
    end
    expect_result(40'd91, 16'd6, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      push_pair(16'(i), 16'(i), 1'b0);
      if (i == 3) check("in_ready_after_3", 64'(in_ready), 64'd1);
    end
    check("in_ready_after_4", 64'(in_ready), 64'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_sum", 64'(out_sum), 64'd6);
      check("hold_count", 64'(out_count), 64'd1);
      check("hold_start", 64'(mul_start), 64'd0);
      check("hold_full", 64'(in_ready), 64'd0);
    end
    @(posedge Clock);
    #1;
    out_ready = 1'b1;
    push_pair(16'd5, 16'd5, 1'b0);
    push_pair(16'd6, 16'd6, 1'b1);
    wait_drain();

    // Reset while K is busy with a nonzero pair.
    push_pair(16'd100, 16'd200, 1'b1);
    begin
      int guard = 0;
      while (!mul_start && guard < 50) begin
        @(negedge Clock);
        guard++;
      end
      check("abort_start_seen", 64'(mul_start), 64'd1);
    end
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    check("abort_mul_start", 64'(mul_start), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_sum", 64'(out_sum), 64'd0);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    expect_result(40'd56, 16'd1, 1'b0);
    push_pair(16'd7, 16'd8, 1'b1);
    wait_drain();

    check("start_total", 64'(starts), 64'd525);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
